// File: rtl/tea_wb_pkg.sv
// Shared register map, bit positions, FSM states and payload structs for the
// TEA Wishbone host interface.
package tea_wb_pkg;

    localparam int unsigned REG_V0     = 0;
    localparam int unsigned REG_V1     = 1;
    localparam int unsigned REG_KEY0   = 2;
    localparam int unsigned REG_KEY1   = 3;
    localparam int unsigned REG_KEY2   = 4;
    localparam int unsigned REG_KEY3   = 5;
    localparam int unsigned REG_CTRL   = 6;
    localparam int unsigned REG_STATUS = 7;
    localparam int unsigned REG_OUT0   = 8;
    localparam int unsigned REG_OUT1   = 9;
    localparam int unsigned REG_CYCLES = 10;

    // Only indices up to STATUS accept writes.
    localparam int unsigned WR_NUM = REG_STATUS + 1;

    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_MODE   = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;

    localparam int unsigned ST_BUSY     = 0;
    localparam int unsigned ST_DONE     = 1;
    localparam int unsigned ST_TIMEOUT  = 2;
    localparam int unsigned ST_ZERO_ERR = 3;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        WAIT_DONE,
        CAPTURE
    } tea_state_e;

    typedef struct packed {
        logic [31:0] v0;
        logic [31:0] v1;
        logic [31:0] key0;
        logic [31:0] key1;
        logic [31:0] key2;
        logic [31:0] key3;
    } tea_opnd_t;

    typedef struct packed {
        logic [31:0] v0;
        logic [31:0] v1;
        logic [31:0] key0;
        logic [31:0] key1;
        logic [31:0] key2;
        logic [31:0] key3;
        logic [31:0] ctrl;
        logic [31:0] status;
        logic [31:0] out0;
        logic [31:0] out1;
        logic [31:0] cycles;
    } tea_regs_t;

    // The cores never launch on a zero operand word.
    function automatic logic opnd_has_zero(input tea_opnd_t o);
        return (o.v0 == '0) || (o.v1 == '0) || (o.key0 == '0) ||
               (o.key1 == '0) || (o.key2 == '0) || (o.key3 == '0);
    endfunction

endpackage

// File: rtl/tea_wb_slave.sv
// Wishbone classic slave: one-wait-state registered ack, address decode into
// write strobes, and registered readback of the register view.
module tea_wb_slave
    import tea_wb_pkg::*;
#(
    parameter int unsigned ADR_W = 4
) (
    input  logic              clk,
    input  logic              wb_rst_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [ADR_W+1:0]  wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  tea_regs_t         regs,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic [WR_NUM-1:0] wr_sel_c,
    output logic [31:0]       wr_data_c
);

    logic             req_c;
    logic [ADR_W-1:0] idx_c;
    logic [31:0]      rd_c;
    logic             unused_adr;

    assign req_c      = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign idx_c      = wb_adr_i[ADR_W+1:2];
    assign unused_adr = ^wb_adr_i[1:0];
    assign wr_data_c  = wb_dat_i;

    // Write strobes fire on the edge that raises ack.
    always_comb begin
        wr_sel_c = '0;
        for (int unsigned i = 0; i < WR_NUM; i++) begin
            if (req_c && wb_we_i && (idx_c == ADR_W'(i))) begin
                wr_sel_c[i] = 1'b1;
            end
        end
    end

    always_comb begin
        rd_c = '0;
        case (idx_c)
            ADR_W'(REG_V0):     rd_c = regs.v0;
            ADR_W'(REG_V1):     rd_c = regs.v1;
            ADR_W'(REG_KEY0):   rd_c = regs.key0;
            ADR_W'(REG_KEY1):   rd_c = regs.key1;
            ADR_W'(REG_KEY2):   rd_c = regs.key2;
            ADR_W'(REG_KEY3):   rd_c = regs.key3;
            ADR_W'(REG_CTRL):   rd_c = regs.ctrl;
            ADR_W'(REG_STATUS): rd_c = regs.status;
            ADR_W'(REG_OUT0):   rd_c = regs.out0;
            ADR_W'(REG_OUT1):   rd_c = regs.out1;
            ADR_W'(REG_CYCLES): rd_c = regs.cycles;
            default:            rd_c = '0;
        endcase
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= req_c;
            wb_dat_o <= (req_c && !wb_we_i) ? rd_c : '0;
        end
    end

endmodule

// File: rtl/tea_wb_host_if.sv
// Register front-end for the paired TEA cores: loads operands, runs one
// operation per START, captures results. TEA_WB_IRQ_EN adds irq_o.
module tea_wb_host_if
    import tea_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADR_W          = 4
) (
    input  logic             clk,
    input  logic             wb_rst_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    input  logic [ADR_W+1:0] wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    output logic [31:0]      rega,
    output logic [31:0]      regb,
    output logic [31:0]      key0,
    output logic [31:0]      key1,
    output logic [31:0]      key2,
    output logic [31:0]      key3,
    input  logic [31:0]      v0eout,
    input  logic [31:0]      v1eout,
    input  logic [31:0]      v0dout,
    input  logic [31:0]      v1dout,
    input  logic             done_enc,
    input  logic             done_dec
`ifdef TEA_WB_IRQ_EN
    ,
    output logic             irq_o
`endif
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    tea_state_e        state_q, state_n;
    tea_opnd_t         opnd_q, opnd_n;
    tea_opnd_t         drv_q, drv_n;
    logic              mode_q, mode_n;
    logic              op_mode_q, op_mode_n;
    logic              done_q, done_n;
    logic              timeout_q, timeout_n;
    logic              zero_err_q, zero_err_n;
    logic [31:0]       out0_q, out0_n;
    logic [31:0]       out1_q, out1_n;
    logic [31:0]       cycles_q, cycles_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic              irq_en_c;

    tea_regs_t         regs;
    logic [WR_NUM-1:0] wr_sel_c;
    logic [31:0]       wr_data_c;
    logic              busy_c;
    logic              start_c;
    logic              sel_done_c;

`ifdef TEA_WB_IRQ_EN
    logic irq_en_q, irq_en_n;
    logic irq_q, irq_n;
    assign irq_en_c = irq_en_q;
    assign irq_o    = irq_q;
`else
    assign irq_en_c = 1'b0;
`endif

    tea_wb_slave #(
        .ADR_W (ADR_W)
    ) u_slave (
        .clk       (clk),
        .wb_rst_i  (wb_rst_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_stb_i  (wb_stb_i),
        .wb_we_i   (wb_we_i),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .regs      (regs),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o),
        .wr_sel_c  (wr_sel_c),
        .wr_data_c (wr_data_c)
    );

    assign busy_c     = (state_q != IDLE);
    assign start_c    = wr_sel_c[REG_CTRL] & wr_data_c[CTRL_START];
    assign sel_done_c = op_mode_q ? done_dec : done_enc;

    assign regs = '{
        v0:     opnd_q.v0,
        v1:     opnd_q.v1,
        key0:   opnd_q.key0,
        key1:   opnd_q.key1,
        key2:   opnd_q.key2,
        key3:   opnd_q.key3,
        ctrl:   {29'd0, irq_en_c, mode_q, 1'b0},
        status: {28'd0, zero_err_q, timeout_q, done_q, busy_c},
        out0:   out0_q,
        out1:   out1_q,
        cycles: cycles_q
    };

    assign rega = drv_q.v0;
    assign regb = drv_q.v1;
    assign key0 = drv_q.key0;
    assign key1 = drv_q.key1;
    assign key2 = drv_q.key2;
    assign key3 = drv_q.key3;

    // Next-state, register-file and status logic.
    always_comb begin
        state_n    = state_q;
        opnd_n     = opnd_q;
        drv_n      = drv_q;
        mode_n     = mode_q;
        op_mode_n  = op_mode_q;
        done_n     = done_q;
        timeout_n  = timeout_q;
        zero_err_n = zero_err_q;
        out0_n     = out0_q;
        out1_n     = out1_q;
        cycles_n   = cycles_q;
        cnt_n      = cnt_q;
`ifdef TEA_WB_IRQ_EN
        irq_en_n   = irq_en_q;
        irq_n      = 1'b0;
`endif

        if (!busy_c) begin
            if (wr_sel_c[REG_V0])   opnd_n.v0   = wr_data_c;
            if (wr_sel_c[REG_V1])   opnd_n.v1   = wr_data_c;
            if (wr_sel_c[REG_KEY0]) opnd_n.key0 = wr_data_c;
            if (wr_sel_c[REG_KEY1]) opnd_n.key1 = wr_data_c;
            if (wr_sel_c[REG_KEY2]) opnd_n.key2 = wr_data_c;
            if (wr_sel_c[REG_KEY3]) opnd_n.key3 = wr_data_c;
        end

        if (wr_sel_c[REG_CTRL]) begin
            mode_n = wr_data_c[CTRL_MODE];
`ifdef TEA_WB_IRQ_EN
            irq_en_n = wr_data_c[CTRL_IRQ_EN];
`endif
        end

        // W1C first, so FSM sets below win in the same cycle.
        if (wr_sel_c[REG_STATUS]) begin
            if (wr_data_c[ST_DONE])     done_n     = 1'b0;
            if (wr_data_c[ST_TIMEOUT])  timeout_n  = 1'b0;
            if (wr_data_c[ST_ZERO_ERR]) zero_err_n = 1'b0;
        end

        case (state_q)
            IDLE: begin
                drv_n = '0;
                if (start_c) begin
                    if (opnd_has_zero(opnd_q)) begin
                        zero_err_n = 1'b1;
                    end else begin
                        done_n    = 1'b0;
                        timeout_n = 1'b0;
                        op_mode_n = wr_data_c[CTRL_MODE];
                        state_n   = ARM;
                    end
                end
            end
            ARM: begin
                drv_n   = opnd_q;
                cnt_n   = '0;
                state_n = WAIT_DONE;
            end
            WAIT_DONE: begin
                cnt_n = cnt_q + CNT_W'(1);
                if (sel_done_c) begin
                    drv_n   = '0;
                    state_n = CAPTURE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_n = 1'b1;
                    drv_n     = '0;
                    state_n   = IDLE;
                end
            end
            CAPTURE: begin
                out0_n   = op_mode_q ? v0dout : v0eout;
                out1_n   = op_mode_q ? v1dout : v1eout;
                done_n   = 1'b1;
                cycles_n = 32'(cnt_q);
                drv_n    = '0;
                state_n  = IDLE;
            end
            default: begin
                drv_n   = '0;
                state_n = IDLE;
            end
        endcase

`ifdef TEA_WB_IRQ_EN
        irq_n = irq_en_n & (done_n | timeout_n);
`endif
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            opnd_q     <= '0;
            drv_q      <= '0;
            mode_q     <= 1'b0;
            op_mode_q  <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            zero_err_q <= 1'b0;
            out0_q     <= '0;
            out1_q     <= '0;
            cycles_q   <= '0;
            cnt_q      <= '0;
`ifdef TEA_WB_IRQ_EN
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_n;
            opnd_q     <= opnd_n;
            drv_q      <= drv_n;
            mode_q     <= mode_n;
            op_mode_q  <= op_mode_n;
            done_q     <= done_n;
            timeout_q  <= timeout_n;
            zero_err_q <= zero_err_n;
            out0_q     <= out0_n;
            out1_q     <= out1_n;
            cycles_q   <= cycles_n;
            cnt_q      <= cnt_n;
`ifdef TEA_WB_IRQ_EN
            irq_en_q   <= irq_en_n;
            irq_q      <= irq_n;
`endif
        end
    end

endmodule
